// File: rtl/wb_arbiter_pkg.sv
// Shared widths and writeback types for the register-file write arbiter.
package wb_arbiter_pkg;
  localparam int DATA_W         = 32;
  localparam int ADDR_W         = 5;
  localparam int NREGS          = 1 << ADDR_W;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_BUF  = 2'd2
  } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO holding mul/div writebacks until the write port is free.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);
  localparam int PW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [PW:0] wr_ptr, rd_ptr;
  wb_req_t     mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write arbiter: ALU has priority, mul/div results are buffered,
// and a pending scoreboard flags reads of registers with an outstanding mul/div.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_we,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_waddr,
  input  logic [DATA_W-1:0] md_wdata,
  output logic              md_ready,
  input  logic              md_issue,
  input  logic [ADDR_W-1:0] md_issue_waddr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] raddr3,
  output logic              hazard,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);
  logic       full, empty, push, pop;
  wb_req_t    din, head;
  wb_src_e    src;
  logic [NREGS-1:0] pending_q, pending_d;

  // Results to x0 are acknowledged but never stored.
  assign md_ready = rst & ~full;
  assign push     = md_valid & md_ready & (md_waddr != '0);
  assign din      = '{waddr: md_waddr, wdata: md_wdata};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (din),
    .full (full),
    .empty(empty),
    .head (head)
  );

  always_comb begin
    src = SRC_NONE;
    if (rst) begin
      if (alu_we && alu_waddr != '0) src = SRC_ALU;
      else if (!empty)               src = SRC_BUF;
    end
  end

  assign pop = (src == SRC_BUF);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (src)
      SRC_ALU: begin
        rf_we    = 1'b1;
        rf_waddr = alu_waddr;
        rf_wdata = alu_wdata;
      end
      SRC_BUF: begin
        rf_we    = 1'b1;
        rf_waddr = head.waddr;
        rf_wdata = head.wdata;
      end
      default: ;
    endcase
  end

  // Clear on buffered writeback first so a same-edge issue to that register wins.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head.waddr] = 1'b0;
    if (md_issue && md_issue_waddr != '0) pending_d[md_issue_waddr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  assign hazard = rst & (pending_q[raddr1] | pending_q[raddr2] | pending_q[raddr3]);
  assign busy   = rst & (md_issue_waddr != '0) & pending_q[md_issue_waddr];
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed test of wb_arbiter: priority, buffering, scoreboard, x0 and reset.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        md_valid;
  logic [4:0]  md_waddr;
  logic [31:0] md_wdata;
  logic        md_ready;
  logic        md_issue;
  logic [4:0]  md_issue_waddr;
  logic [4:0]  raddr1, raddr2, raddr3;
  logic        hazard, busy, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int passed = 0;
  int total  = 0;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .md_valid(md_valid), .md_waddr(md_waddr), .md_wdata(md_wdata), .md_ready(md_ready),
    .md_issue(md_issue), .md_issue_waddr(md_issue_waddr),
    .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
    .hazard(hazard), .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change 2 time units after a rising edge; settle 1 unit before checks.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
    chk({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, a});
    chk({tag, "_wdata"}, rf_wdata, d);
  endtask

  initial begin
    rst = 1'b0; alu_we = 0; alu_waddr = 0; alu_wdata = 0;
    md_valid = 0; md_waddr = 0; md_wdata = 0;
    md_issue = 0; md_issue_waddr = 0; raddr1 = 0; raddr2 = 0; raddr3 = 0;

    // Reset state, even with ALU driving
    #12; alu_we = 1; alu_waddr = 5'd3; alu_wdata = 32'h11; #1;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_md_ready", {31'd0, md_ready}, 32'd0);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    alu_we = 0; alu_waddr = 0; alu_wdata = 0;
    @(negedge clk); rst = 1'b1;
    tick(); #1;
    chk("post_rst_md_ready", {31'd0, md_ready}, 32'd1);
    chk_wr("idle", 1'b0, 5'd0, 32'd0);

    // Solo mul/div to x7
    md_issue = 1; md_issue_waddr = 5'd7;
    tick(); md_issue = 0; raddr1 = 5'd7; #1;
    chk("solo_busy", {31'd0, busy}, 32'd1);
    chk("solo_hazard", {31'd0, hazard}, 32'd1);
    md_valid = 1; md_waddr = 5'd7; md_wdata = 32'hDEADBEEF; #1;
    chk("solo_ready", {31'd0, md_ready}, 32'd1);
    chk("solo_no_bypass", {31'd0, rf_we}, 32'd0);
    tick(); md_valid = 0; #1;
    chk_wr("solo_wr", 1'b1, 5'd7, 32'hDEADBEEF);
    chk("solo_hazard_held", {31'd0, hazard}, 32'd1);
    tick(); #1;
    chk("solo_cleared", {31'd0, hazard}, 32'd0);
    chk_wr("solo_idle", 1'b0, 5'd0, 32'd0);
    raddr1 = 0; md_issue_waddr = 0;

    // ALU priority over two buffered results (8 then 9)
    md_issue = 1; md_issue_waddr = 5'd8; tick();
    md_issue_waddr = 5'd9; tick(); md_issue = 0;
    alu_we = 1; alu_waddr = 5'd3; alu_wdata = 32'h11;
    md_valid = 1; md_waddr = 5'd8; md_wdata = 32'h88; tick();
    md_waddr = 5'd9; md_wdata = 32'h99; tick(); md_valid = 0; #1;
    chk("conf_full", {31'd0, md_ready}, 32'd0);
    chk_wr("conf_alu1", 1'b1, 5'd3, 32'h11);
    tick(); #1; chk_wr("conf_alu2", 1'b1, 5'd3, 32'h11);
    tick(); #1; chk_wr("conf_alu3", 1'b1, 5'd3, 32'h11);
    chk("conf_full3", {31'd0, md_ready}, 32'd0);
    alu_we = 0; alu_waddr = 0; alu_wdata = 0; #1;
    chk_wr("conf_md8", 1'b1, 5'd8, 32'h88);
    chk("conf_full_pop", {31'd0, md_ready}, 32'd0);
    tick(); #1;
    chk_wr("conf_md9", 1'b1, 5'd9, 32'h99);
    chk("conf_ready", {31'd0, md_ready}, 32'd1);
    raddr1 = 5'd8; raddr2 = 5'd9; #1;
    chk("conf_pend9", {31'd0, hazard}, 32'd1);
    tick(); #1;
    chk_wr("conf_idle", 1'b0, 5'd0, 32'd0);
    chk("conf_cleared", {31'd0, hazard}, 32'd0);
    raddr1 = 0; raddr2 = 0;

    // Hazard on raddr2, x0 reads never hazard
    md_issue = 1; md_issue_waddr = 5'd12; tick(); md_issue = 0; md_issue_waddr = 0;
    raddr2 = 5'd12; #1;
    chk("haz_r2", {31'd0, hazard}, 32'd1);
    raddr2 = 0; #1;
    chk("haz_x0", {31'd0, hazard}, 32'd0);
    raddr3 = 5'd12; #1;
    chk("haz_r3", {31'd0, hazard}, 32'd1);
    alu_we = 1; alu_waddr = 5'd12; alu_wdata = 32'h1; tick();
    alu_we = 0; alu_waddr = 0; alu_wdata = 0; #1;
    chk("haz_alu_no_clear", {31'd0, hazard}, 32'd1);
    md_valid = 1; md_waddr = 5'd12; md_wdata = 32'hC; tick(); md_valid = 0;
    tick(); #1;
    chk("haz_cleared", {31'd0, hazard}, 32'd0);
    raddr3 = 0;

    // Same-edge clear of x4 and issue to x4: set wins
    md_issue = 1; md_issue_waddr = 5'd4; tick(); md_issue = 0;
    md_valid = 1; md_waddr = 5'd4; md_wdata = 32'h44; tick(); md_valid = 0;
    md_issue = 1; md_issue_waddr = 5'd4; #1;
    chk_wr("same_head4", 1'b1, 5'd4, 32'h44);
    tick(); md_issue = 0; #1;
    chk("same_busy", {31'd0, busy}, 32'd1);
    raddr1 = 5'd4; #1;
    chk("same_pending", {31'd0, hazard}, 32'd1);
    raddr1 = 0;
    md_valid = 1; md_waddr = 5'd4; md_wdata = 32'h45; tick(); md_valid = 0; tick();
    md_issue_waddr = 0;

    // x0 results are accepted and dropped; ALU writes to x0 yield to the buffer
    md_valid = 1; md_waddr = 5'd0; md_wdata = 32'hBAD; #1;
    chk("x0_ready", {31'd0, md_ready}, 32'd1);
    tick(); md_valid = 0; #1;
    chk_wr("x0_dropped", 1'b0, 5'd0, 32'd0);
    alu_we = 1; alu_waddr = 5'd5; alu_wdata = 32'h5;
    md_valid = 1; md_waddr = 5'd20; md_wdata = 32'h2020; tick(); md_valid = 0;
    alu_waddr = 5'd0; alu_wdata = 32'h55; #1;
    chk_wr("x0_alu_yields", 1'b1, 5'd20, 32'h2020);
    tick(); alu_we = 0; alu_wdata = 0; #1;
    chk_wr("x0_idle", 1'b0, 5'd0, 32'd0);

    // Reset mid-traffic: two buffered results, pending[5]
    md_issue = 1; md_issue_waddr = 5'd5; tick(); md_issue = 0; md_issue_waddr = 0;
    alu_we = 1; alu_waddr = 5'd3; alu_wdata = 32'h11;
    md_valid = 1; md_waddr = 5'd10; md_wdata = 32'hA; tick();
    md_waddr = 5'd11; md_wdata = 32'hB; tick(); md_valid = 0;
    raddr1 = 5'd5; #1;
    chk("mid_full", {31'd0, md_ready}, 32'd0);
    chk("mid_hazard", {31'd0, hazard}, 32'd1);
    rst = 1'b0; #1;
    chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_hazard", {31'd0, hazard}, 32'd0);
    alu_we = 0; alu_waddr = 0; alu_wdata = 0;
    @(negedge clk); rst = 1'b1;
    tick(); #1;
    chk("mid_rel_ready", {31'd0, md_ready}, 32'd1);
    chk_wr("mid_rel_empty", 1'b0, 5'd0, 32'd0);
    chk("mid_rel_hazard", {31'd0, hazard}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, depth of the mul/div result buffer (power of two, >=2).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port alu_we  in  1  ALU writeback valid; no backpressure.
REQ-005 SHALL have port alu_waddr  in  5  ALU destination register.
REQ-006 SHALL have port alu_wdata  in  32  ALU result.
REQ-007 SHALL have port md_valid  in  1  mul/div result valid.
REQ-008 SHALL have port md_waddr  in  5  mul/div destination register.
REQ-009 SHALL have port md_wdata  in  32  mul/div result.
REQ-010 SHALL have port md_ready  out  1  buffer can accept a mul/div result.
REQ-011 SHALL have port md_issue  in  1  ID issues a mul/div op this cycle.
REQ-012 SHALL have port md_issue_waddr  in  5  destination of issued mul/div op.
REQ-013 SHALL have port raddr1/raddr2/raddr3  in  5 each  ID read addresses to check.
REQ-014 SHALL have port hazard  out  1  a read address targets a pending register.
REQ-015 SHALL have port busy  out  1  md_issue_waddr already pending.
REQ-016 SHALL have port rf_we/rf_waddr/rf_wdata  out  1/5/32  register-file write port.

Function
REQ-017 SHALL accept a mul/div result on cycle where md_valid & md_ready; md_ready = buffer not full (combinational).
REQ-018 SHALL enqueue accepted results with md_waddr != 0; results to x0 accepted and dropped.
REQ-019 SHALL drive write port combinationally: alu_we & alu_waddr!=0 -> ALU data; else buffer non-empty -> buffer head, popped at edge; else rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-020 SHALL give ALU absolute priority; buffered results wait while ALU writes every cycle.
REQ-021 SHALL impose minimum latency 1 cycle from mul/div acceptance to rf_we (no bypass).
REQ-022 SHALL allow enqueue and dequeue on the same edge when full; md_ready stays 0 that cycle (full-based, not pop-aware).
REQ-023 SHALL keep a 32-bit pending scoreboard: set bit md_issue_waddr on md_issue (ignored for x0); clear bit rf_waddr when a buffered result is written.
REQ-024 SHALL make set win over clear for the same address on the same edge.
REQ-025 SHALL drive hazard = pending[raddr1] | pending[raddr2] | pending[raddr3], x0 never pending.
REQ-026 SHALL drive busy = md_issue_waddr!=0 & pending[md_issue_waddr]; ID SHALL not assert md_issue while busy (no per-register count).
REQ-027 SHALL not clear pending on ALU writes to a pending register.
REQ-028 SHALL preserve FIFO order of mul/div writes.

Reset
REQ-029 SHALL, while rst=0, force buffer empty, pointers 0, pending all 0, rf_we=0, md_ready=0, hazard=0, busy=0 regardless of clock.
REQ-030 SHALL discard buffered results and pending bits if reset asserts mid-operation; md_ready=1 first cycle after release.

Structure
REQ-031 SHALL take DATA_W=32, ADDR_W=5, FIFO_DEPTH default from the shared CPU package.
REQ-032 SHALL implement the buffer as sub-module wb_fifo (push/pop/full/empty/head, async active-low reset).
REQ-033 SHALL keep scoreboard and priority mux in wb_arbiter itself.

Verification
REQ-034 Reset mid-traffic: 2 results buffered, pending[5]=1, pull rst low between edges -> rf_we=0, hazard=0 immediately; md_ready=1 after release.
REQ-035 Solo mul/div: md_issue waddr=7, later md_valid waddr=7 data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF; pending[7] cleared following edge.
REQ-036 Conflict: alu_we waddr=3 data=0x11 every cycle for 3 cycles while 2 md results (waddr 8, 9) buffered -> md_ready=0, ALU writes 3 cycles, then 8, then 9 in order.
REQ-037 Hazard: pending[12]=1, raddr2=12 -> hazard=1; raddr=0 with pending set elsewhere -> hazard=0.
REQ-038 Same-edge set/clear: head write to reg 4 while md_issue waddr=4 -> pending[4]=1 after edge, busy=1.
REQ-039 x0 handling: md result waddr=0 -> accepted, never rf_we; alu_we waddr=0 -> buffer head written instead.
